// File: rtl/fp64_mul_arbiter_if.sv
// Two-requester handshake bundle for the shared FP64 multiplier arbiter.
// The master side is the requester and the slave side is the arbiter.
interface fp64_mul_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [63:0] req0_a;
   logic [63:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [63:0] req1_a;
   logic [63:0] req1_b;
   logic        resp0_valid;
   logic        resp0_ready;
   logic [63:0] resp0_data;
   logic        resp1_valid;
   logic        resp1_ready;
   logic [63:0] resp1_data;

   modport master (
      output req0_valid, req0_a, req0_b, resp0_ready,
      output req1_valid, req1_a, req1_b, resp1_ready,
      input  req0_ready, resp0_valid, resp0_data,
      input  req1_ready, resp1_valid, resp1_data
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, resp0_ready,
      input  req1_valid, req1_a, req1_b, resp1_ready,
      output req0_ready, resp0_valid, resp0_data,
      output req1_ready, resp1_valid, resp1_data
   );
endinterface

// File: rtl/fp64_mul_arbiter.sv
// Round-robin sharing of one combinational FP64 multiplier between two
// requesters, with a fixed-latency result pipeline and per-requester hold.
module fp64_mul_arbiter #(
   parameter int LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   fp64_mul_arbiter_if.slave   bus,
   output logic [63:0]         mul_a,
   output logic [63:0]         mul_b,
   input  logic [63:0]         mul_result,
   output logic                busy
);

   logic [1:0]  outstanding;
   logic [1:0]  resp_valid_q;
   logic        last_grant;
   logic [63:0] resp0_q;
   logic [63:0] resp1_q;
   logic        elig0, elig1;
   logic        gnt0, gnt1, gnt_any;
   logic        hs0, hs1;
   logic        tail_v, tail_id;
   logic [63:0] tail_d;

   // Eligibility uses the registered flag, so a returning response
   // never re-enables its own requester in the same cycle.
   always_comb begin
      elig0   = bus.req0_valid & ~outstanding[0] & ~rst;
      elig1   = bus.req1_valid & ~outstanding[1] & ~rst;
      gnt0    = elig0 & (~elig1 | last_grant);
      gnt1    = elig1 & (~elig0 | ~last_grant);
      gnt_any = gnt0 | gnt1;
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (gnt0) begin
         mul_a = bus.req0_a;
         mul_b = bus.req0_b;
      end else if (gnt1) begin
         mul_a = bus.req1_a;
         mul_b = bus.req1_b;
      end
   end

   assign hs0 = resp_valid_q[0] & bus.resp0_ready;
   assign hs1 = resp_valid_q[1] & bus.resp1_ready;

   // The response register acts as the last stage, so LAT-1 stages sit
   // between the grant and the response hold register.
   generate
      if (LAT == 1) begin : g_direct
         assign tail_v  = gnt_any;
         assign tail_id = gnt1;
         assign tail_d  = mul_result;
      end else begin : g_pipe
         logic        sv  [LAT-1];
         logic        sid [LAT-1];
         logic [63:0] sd  [LAT-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < LAT-1; k++) begin
                  sv[k]  <= 1'b0;
                  sid[k] <= 1'b0;
                  sd[k]  <= '0;
               end
            end else begin
               sv[0]  <= gnt_any;
               sid[0] <= gnt1;
               sd[0]  <= mul_result;
               for (int k = 1; k < LAT-1; k++) begin
                  sv[k]  <= sv[k-1];
                  sid[k] <= sid[k-1];
                  sd[k]  <= sd[k-1];
               end
            end
         end

         assign tail_v  = sv[LAT-2];
         assign tail_id = sid[LAT-2];
         assign tail_d  = sd[LAT-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding  <= 2'b00;
         resp_valid_q <= 2'b00;
         last_grant   <= 1'b1;
         resp0_q      <= '0;
         resp1_q      <= '0;
      end else begin
         if (gnt_any) last_grant <= gnt1;
         outstanding[0] <= (outstanding[0] & ~hs0) | gnt0;
         outstanding[1] <= (outstanding[1] & ~hs1) | gnt1;
         if (tail_v & ~tail_id) begin
            resp_valid_q[0] <= 1'b1;
            resp0_q         <= tail_d;
         end else if (hs0) begin
            resp_valid_q[0] <= 1'b0;
         end
         if (tail_v & tail_id) begin
            resp_valid_q[1] <= 1'b1;
            resp1_q         <= tail_d;
         end else if (hs1) begin
            resp_valid_q[1] <= 1'b0;
         end
      end
   end

   // Registered outputs are masked during reset so the first reset
   // cycle already presents the idle state.
   assign bus.resp0_valid = resp_valid_q[0] & ~rst;
   assign bus.resp1_valid = resp_valid_q[1] & ~rst;
   assign bus.resp0_data  = rst ? '0 : resp0_q;
   assign bus.resp1_data  = rst ? '0 : resp1_q;
   assign busy = ~rst & ((|outstanding) | (|resp_valid_q));

endmodule
